// File: rtl/agu_param_pkg.sv
// Shared constants, state encoding and width helpers for the parametrised FFT AGU.
package agu_param_pkg;

    localparam int N_LOG2_MAX_DEF = 10;
    localparam int BFU_LAT_DEF    = 4;
    localparam int BATCH_W_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_WAIT,
        ST_DONE
    } agu_state_t;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/agu_addr_calc.sv
// Combinational butterfly descriptor mapping: (stage, group, j) -> operand
// addresses, twiddle index and end-of-loop flags for a radix-2 DIT schedule.
module agu_addr_calc
    import agu_param_pkg::*;
#(
    parameter int N_LOG2_MAX = N_LOG2_MAX_DEF
) (
    input  logic [$clog2(N_LOG2_MAX+1)-1:0] log2n,
    input  logic [$clog2(N_LOG2_MAX)-1:0]   stage,
    input  logic [N_LOG2_MAX-1:0]           group,
    input  logic [N_LOG2_MAX-1:0]           j,
    output logic [N_LOG2_MAX-1:0]           addr_a,
    output logic [N_LOG2_MAX-1:0]           addr_b,
    output logic [N_LOG2_MAX-2:0]           twiddle_idx,
    output logic                            last_j,
    output logic                            last_group,
    output logic                            last_stage
);

    localparam int AW = N_LOG2_MAX;
    localparam int LW = $clog2(N_LOG2_MAX + 1);
    localparam int SW = $clog2(N_LOG2_MAX);
    // Common width for log2n/stage arithmetic so neither operand truncates.
    localparam int CW = ((LW > SW) ? LW : SW) + 1;
    localparam logic [AW-1:0] ONE = AW'(1);

    logic [CW-1:0] log2n_w;
    logic [CW-1:0] stage_w;
    logic [CW-1:0] gshift;
    logic [SW:0]   pair_sh;
    logic [SW-1:0] tw_sh;
    logic [AW-1:0] stride;
    logic [AW-1:0] grp_max;

    assign log2n_w = CW'(log2n);
    assign stage_w = CW'(stage);

    // Butterfly span is 2^stage; each group covers two spans.
    assign stride  = ONE << stage;
    assign pair_sh = {1'b0, stage} + (SW+1)'(1);
    assign addr_a  = (group << pair_sh) + j;
    assign addr_b  = addr_a + stride;

    // Twiddle ROM is sized for the largest FFT, so the index is scaled
    // to N_MAX regardless of the programmed size.
    assign tw_sh       = SW'(AW - 1) - stage;
    assign twiddle_idx = j[AW-2:0] << tw_sh;

    // Groups per stage = 2^(log2n - stage - 1).
    assign gshift  = log2n_w - stage_w - CW'(1);
    assign grp_max = (ONE << gshift) - ONE;

    assign last_j     = (j == stride - ONE);
    assign last_group = (group == grp_max);
    assign last_stage = (stage_w == log2n_w - CW'(1));

endmodule

// File: rtl/agu_param.sv
// Run-time sized radix-2 DIT address generation unit. Sequences butterfly
// descriptors stage by stage with BFU backpressure, flushes the BFU pipeline
// between stages, ping-pongs the RAM banks, and repeats over a frame batch.
module agu_param
    import agu_param_pkg::*;
#(
    parameter int N_LOG2_MAX = N_LOG2_MAX_DEF,
    parameter int BFU_LAT    = BFU_LAT_DEF,
    parameter int BATCH_W    = BATCH_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [$clog2(N_LOG2_MAX+1)-1:0] cfg_log2n,
    input  logic                            cfg_inverse,
    input  logic [BATCH_W-1:0]              cfg_batches,
    input  logic                            issue_ready,
    input  logic                            next_ready,
    output logic                            issue_valid,
    output logic [N_LOG2_MAX-1:0]           rd_addrA,
    output logic [N_LOG2_MAX-1:0]           rd_addrB,
    output logic [N_LOG2_MAX-2:0]           twiddle_idx,
    output logic                            tw_conj,
    output logic [$clog2(N_LOG2_MAX)-1:0]   stage,
    output logic                            bank_sel,
    output logic [BATCH_W-1:0]              batch_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            cfg_err
);

    localparam int AW = N_LOG2_MAX;
    localparam int LW = $clog2(N_LOG2_MAX + 1);
    localparam int SW = $clog2(N_LOG2_MAX);
    localparam int FW = cnt_w(BFU_LAT - 1);
    localparam logic [AW-1:0]      ONE        = AW'(1);
    localparam logic [FW-1:0]      FLUSH_INIT = FW'(BFU_LAT - 1);
    localparam logic [LW-1:0]      LOG2N_MAX  = LW'(N_LOG2_MAX);
    localparam logic [BATCH_W-1:0] BATCH_ONE  = BATCH_W'(1);

    agu_state_t         state_q, state_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [AW-1:0]      group_q, group_d;
    logic [AW-1:0]      j_q, j_d;
    logic [BATCH_W-1:0] batch_q, batch_d;
    logic               bank_q, bank_d;
    logic [FW-1:0]      flush_q, flush_d;
    logic [LW-1:0]      log2n_q, log2n_d;
    logic               inv_q, inv_d;
    logic [BATCH_W-1:0] batches_q, batches_d;
    logic               cfg_err_q, cfg_err_d;

    logic [AW-1:0]      addr_a;
    logic [AW-1:0]      addr_b;
    logic [AW-2:0]      tw_idx;
    logic               last_j;
    logic               last_group;
    logic               last_stage;
    logic               cfg_bad;
    logic               in_run;

    agu_addr_calc #(
        .N_LOG2_MAX (N_LOG2_MAX)
    ) u_addr_calc (
        .log2n       (log2n_q),
        .stage       (stage_q),
        .group       (group_q),
        .j           (j_q),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .twiddle_idx (tw_idx),
        .last_j      (last_j),
        .last_group  (last_group),
        .last_stage  (last_stage)
    );

    assign cfg_bad = (cfg_log2n == '0) || (cfg_log2n > LOG2N_MAX) || (cfg_batches == '0);

    // Next-state and counter update; abort overrides every transition.
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        group_d   = group_q;
        j_d       = j_q;
        batch_d   = batch_q;
        bank_d    = bank_q;
        flush_d   = flush_q;
        log2n_d   = log2n_q;
        inv_d     = inv_q;
        batches_d = batches_q;
        cfg_err_d = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            stage_d = '0;
            group_d = '0;
            j_d     = '0;
            batch_d = '0;
            bank_d  = 1'b0;
            flush_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        log2n_d   = cfg_log2n;
                        inv_d     = cfg_inverse;
                        batches_d = cfg_batches;
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            stage_d = '0;
                            group_d = '0;
                            j_d     = '0;
                            batch_d = '0;
                            bank_d  = 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    // j is the inner loop within a group, group the outer.
                    if (issue_ready) begin
                        if (last_j) begin
                            j_d = '0;
                            if (last_group) begin
                                group_d = '0;
                                flush_d = FLUSH_INIT;
                                state_d = ST_FLUSH;
                            end else begin
                                group_d = group_q + ONE;
                            end
                        end else begin
                            j_d = j_q + ONE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_q != '0) begin
                        flush_d = flush_q - FW'(1);
                    end else if (!last_stage) begin
                        stage_d = stage_q + SW'(1);
                        group_d = '0;
                        j_d     = '0;
                        bank_d  = ~bank_q;
                        state_d = ST_RUN;
                    end else if (batch_q != batches_q - BATCH_ONE) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (next_ready) begin
                        batch_d = batch_q + BATCH_ONE;
                        stage_d = '0;
                        group_d = '0;
                        j_d     = '0;
                        bank_d  = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and latched-config registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            stage_q   <= '0;
            group_q   <= '0;
            j_q       <= '0;
            batch_q   <= '0;
            bank_q    <= 1'b0;
            flush_q   <= '0;
            log2n_q   <= '0;
            inv_q     <= 1'b0;
            batches_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            group_q   <= group_d;
            j_q       <= j_d;
            batch_q   <= batch_d;
            bank_q    <= bank_d;
            flush_q   <= flush_d;
            log2n_q   <= log2n_d;
            inv_q     <= inv_d;
            batches_q <= batches_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Descriptor fields read as zero whenever no butterfly is being offered.
    assign in_run      = (state_q == ST_RUN);
    assign issue_valid = in_run;
    assign rd_addrA    = in_run ? addr_a : '0;
    assign rd_addrB    = in_run ? addr_b : '0;
    assign twiddle_idx = in_run ? tw_idx : '0;
    assign tw_conj     = inv_q;
    assign stage       = stage_q;
    assign bank_sel    = bank_q;
    assign batch_idx   = batch_q;
    assign busy        = in_run || (state_q == ST_FLUSH) || (state_q == ST_WAIT);
    assign done        = (state_q == ST_DONE);
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_agu_param.sv
// Scoreboard bench for agu_param: expected descriptors are queued by the
// stimulus side, and a negedge monitor pops and compares on every accept.
`timescale 1ns/1ps
module tb_agu_param;

    localparam int NL = 10;
    localparam int BL = 4;
    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  cfg_log2n = '0;
    logic        cfg_inverse = 1'b0;
    logic [7:0]  cfg_batches = '0;
    logic        issue_ready = 1'b0;
    logic        next_ready = 1'b0;
    logic        issue_valid;
    logic [9:0]  rd_addrA;
    logic [9:0]  rd_addrB;
    logic [8:0]  twiddle_idx;
    logic        tw_conj;
    logic [3:0]  stage;
    logic        bank_sel;
    logic [7:0]  batch_idx;
    logic        busy;
    logic        done;
    logic        cfg_err;

    agu_param #(
        .N_LOG2_MAX (NL),
        .BFU_LAT    (BL),
        .BATCH_W    (BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_log2n   (cfg_log2n),
        .cfg_inverse (cfg_inverse),
        .cfg_batches (cfg_batches),
        .issue_ready (issue_ready),
        .next_ready  (next_ready),
        .issue_valid (issue_valid),
        .rd_addrA    (rd_addrA),
        .rd_addrB    (rd_addrB),
        .twiddle_idx (twiddle_idx),
        .tw_conj     (tw_conj),
        .stage       (stage),
        .bank_sel    (bank_sel),
        .batch_idx   (batch_idx),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] a;
        logic [9:0] b;
        logic [8:0] tw;
        logic [3:0] stg;
        logic       bank;
        logic [7:0] batch;
        logic       conj;
    } desc_t;

    desc_t sb[$];
    desc_t cur;
    desc_t held;
    logic  held_v = 1'b0;
    logic  done_prev = 1'b0;
    logic  mon_en = 1'b0;
    int    n_tests = 0;
    int    n_fails = 0;
    int    mon_tests = 0;
    int    mon_fails = 0;
    int    mon_acc = 0;
    int    done_rises = 0;

    assign cur = {rd_addrA, rd_addrB, twiddle_idx, stage, bank_sel, batch_idx, tw_conj};

    // Monitor: hold check while stalled, scoreboard compare on accept.
    always @(negedge clk) begin
        desc_t e;
        if (done && !done_prev) done_rises++;
        done_prev = done;
        if (!mon_en || !issue_valid) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                mon_tests++;
                if (cur !== held) begin
                    mon_fails++;
                    $display("FAIL hold actual=%h required=%h", cur, held);
                end
            end
            if (issue_ready) begin
                mon_tests++;
                if (sb.size() == 0) begin
                    mon_fails++;
                    $display("FAIL sb_underflow actual=%h required=none", cur);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e) begin
                        mon_fails++;
                        $display("FAIL desc actual=%h required=%h", cur, e);
                    end
                end
                mon_acc++;
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held   = cur;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Hand-computed n=8 schedule.
    task automatic push_hand8();
        int ha[12] = '{0, 2, 4, 6,   0, 1, 4, 5,   0, 1, 2, 3};
        int hb[12] = '{1, 3, 5, 7,   2, 3, 6, 7,   4, 5, 6, 7};
        int ht[12] = '{0, 0, 0, 0,   0, 256, 0, 256,   0, 128, 256, 384};
        int hs[12] = '{0, 0, 0, 0,   1, 1, 1, 1,   2, 2, 2, 2};
        int hk[12] = '{0, 0, 0, 0,   1, 1, 1, 1,   0, 0, 0, 0};
        desc_t d;
        for (int i = 0; i < 12; i++) begin
            d.a = 10'(ha[i]); d.b = 10'(hb[i]); d.tw = 9'(ht[i]);
            d.stg = 4'(hs[i]); d.bank = 1'(hk[i]); d.batch = '0; d.conj = 1'b0;
            sb.push_back(d);
        end
    endtask

    // Butterfly k of stage s: group k/2^s, offset k mod 2^s.
    task automatic push_frame(input int l, input int bt, input logic cj, input int nstg);
        desc_t d;
        int stride, grp, jj, a;
        for (int s = 0; s < nstg; s++) begin
            stride = 1 << s;
            for (int k = 0; k < (1 << (l - 1)); k++) begin
                grp = k / stride;
                jj  = k % stride;
                a   = grp * 2 * stride + jj;
                d.a = 10'(a); d.b = 10'(a + stride); d.tw = 9'(jj * (1 << (9 - s)));
                d.stg = 4'(s); d.bank = 1'(s % 2); d.batch = 8'(bt); d.conj = cj;
                sb.push_back(d);
            end
        end
    endtask

    // Start a run and step until done; mode 1 applies the 1,0,0,1 stall
    // pattern then random backpressure. WAIT is released after 5 cycles.
    task automatic run_cfg(input int l, input int nb, input logic inv, input int mode,
                           input int budget, output int cyc);
        logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int gap = 0;
        cyc = 0;
        @(posedge clk); #1;
        cfg_log2n = 4'(l); cfg_batches = 8'(nb); cfg_inverse = inv;
        start = 1'b1; issue_ready = 1'b1; next_ready = 1'b0;
        while (cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (done) break;
            if (mode == 1) begin
                if (cyc >= 2 && cyc <= 4) begin
                    chk("stall_hold_a", 64'(rd_addrA), 64'd2);
                    chk("stall_hold_b", 64'(rd_addrB), 64'd3);
                end
                if (cyc <= 4) issue_ready = pat[cyc-1];
                else issue_ready = 1'($urandom_range(0, 1));
            end
            next_ready = 1'b0;
            if (busy && !issue_valid) gap++;
            else gap = 0;
            if (gap == BL + 5) begin
                next_ready = 1'b1;
                gap = 0;
            end
        end
        issue_ready = 1'b1;
        next_ready  = 1'b0;
        chk("done_within_budget", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int acc0;
        int dr0;
        int bad_l[3] = '{0, 11, 3};
        int bad_b[3] = '{1, 1, 0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid", 64'(issue_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_cfg_err", 64'(cfg_err), 0);
        chk("rst_addr", 64'({rd_addrA, rd_addrB, twiddle_idx}), 0);
        chk("rst_ctl", 64'({stage, bank_sel, batch_idx, tw_conj}), 0);

        // n=8, one batch, no stalls.
        mon_en = 1'b1;
        push_hand8();
        run_cfg(3, 1, 1'b0, 0, 200, cyc);
        chk("n8_cycles", 64'(cyc), 64'd25);
        chk("n8_done_busy", 64'(busy), 0);
        chk("n8_done_stage", 64'(stage), 64'd2);
        chk("n8_done_bank", 64'(bank_sel), 0);
        chk("n8_sb_empty", 64'(sb.size()), 0);
        @(posedge clk); #1;
        chk("done_to_idle", 64'(done), 0);

        // n=16 with backpressure.
        push_frame(4, 0, 1'b0, 4);
        run_cfg(4, 1, 1'b0, 1, 3000, cyc);
        chk("n16_sb_empty", 64'(sb.size()), 0);
        @(posedge clk); #1;

        // Rejected configurations.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cfg_log2n = 4'(bad_l[i]); cfg_batches = 8'(bad_b[i]); start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("cfg_err_pulse", 64'(cfg_err), 1);
            chk("cfg_err_busy", 64'(busy), 0);
            @(posedge clk); #1;
            chk("cfg_err_clear", 64'(cfg_err), 0);
            chk("cfg_err_idle", 64'({busy, issue_valid}), 0);
        end

        // Three batches, inverse, WAIT held 5 cycles each time.
        for (int b = 0; b < 3; b++) push_frame(2, b, 1'b1, 2);
        dr0 = done_rises;
        run_cfg(2, 3, 1'b1, 0, 500, cyc);
        chk("batch_final_idx", 64'(batch_idx), 64'd2);
        chk("batch_tw_conj", 64'(tw_conj), 1);
        chk("batch_sb_empty", 64'(sb.size()), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("single_done", 64'(done_rises - dr0), 1);

        // Abort in the FLUSH after stage 1.
        push_frame(3, 0, 1'b0, 2);
        acc0 = mon_acc;
        @(posedge clk); #1;
        cfg_log2n = 4'd3; cfg_batches = 8'd1; cfg_inverse = 1'b0;
        start = 1'b1; issue_ready = 1'b1;
        cyc = 0;
        while ((mon_acc - acc0) < 8 && cyc < 100) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk("abort_reach", 64'(mon_acc - acc0), 64'd8);
        @(posedge clk); #1;
        chk("abort_in_flush", 64'({busy, issue_valid}), 64'b10);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_valid", 64'(issue_valid), 0);
        chk("abort_ctl", 64'({stage, bank_sel, batch_idx}), 0);
        chk("abort_sb_empty", 64'(sb.size()), 0);
        push_hand8();
        run_cfg(3, 1, 1'b0, 0, 200, cyc);
        chk("post_abort_cycles", 64'(cyc), 64'd25);
        chk("post_abort_sb_empty", 64'(sb.size()), 0);
        @(posedge clk); #1;

        // Asynchronous reset between edges while running.
        mon_en = 1'b0;
        @(posedge clk); #1;
        cfg_log2n = 4'd4; cfg_batches = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_valid", 64'(issue_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(issue_valid), 0);
        chk("async_rst_busy", 64'(busy), 0);
        chk("async_rst_addr", 64'({rd_addrA, rd_addrB, twiddle_idx}), 0);
        chk("async_rst_ctl", 64'({stage, bank_sel, batch_idx}), 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 64'({busy, issue_valid, done}), 0);

        n_tests += mon_tests;
        n_fails += mon_fails;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
